// File: rtl/regbank16_pkg.sv
// ----------------------------------------------------------------------------
// regbank16_pkg
//   Shared constants for the regbank16 operand register bank: entry count,
//   default word/address MSB indices and the FSM state encoding.
// ----------------------------------------------------------------------------
package regbank16_pkg;

    // Number of entries; equals the input count of the mux16 operand selector.
    localparam int REG_COUNT = 16;

    // Default MSB indices: 20-bit words, 4-bit addresses.
    localparam int DEFAULT_N = 19;
    localparam int DEFAULT_J = 3;

    // FSM state encoding, kept as plain constants so legacy code can share it.
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

endpackage

// File: rtl/regbank16_if.sv
// ----------------------------------------------------------------------------
// regbank16_if
//   Write/clear port of the regbank16 register bank.
//
//   wr_valid  master->slave  write request
//   wr_ready  slave->master  bank accepts a write this cycle (combinational)
//   wr_addr   master->slave  target entry, J+1 bits
//   wr_data   master->slave  word to store, N+1 bits
//   wr_ack    slave->master  one-cycle pulse after an accepted write
//   clr_req   master->slave  request a full-bank clear sweep
//   busy      slave->master  clear sweep in progress
//   clr_done  slave->master  one-cycle pulse after the last entry is cleared
// ----------------------------------------------------------------------------
interface regbank16_if
    import regbank16_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int J = DEFAULT_J
) ();

    logic       wr_valid;
    logic       wr_ready;
    logic [J:0] wr_addr;
    logic [N:0] wr_data;
    logic       wr_ack;
    logic       clr_req;
    logic       busy;
    logic       clr_done;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output clr_req,
        input  wr_ready,
        input  wr_ack,
        input  busy,
        input  clr_done
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  clr_req,
        output wr_ready,
        output wr_ack,
        output busy,
        output clr_done
    );

endinterface

// File: rtl/regbank16.sv
// ----------------------------------------------------------------------------
// regbank16
//   Sixteen-entry operand register bank. Every entry is exposed in parallel on
//   r0..r15 in the same order and width as the mux16 selector inputs, so the
//   two blocks can be instantiated side by side. Writes arrive on a single
//   valid/ready port; a clear sequencer zeroes one entry per cycle.
//
//   clk       sole clock, rising edge
//   rst       synchronous, active-high reset
//   bus       regbank16_if.slave: write port, clear request, status pulses
//   r0..r15   registered contents of entries 0..15
// ----------------------------------------------------------------------------
module regbank16
    import regbank16_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int J = DEFAULT_J
) (
    input  logic        clk,
    input  logic        rst,
    regbank16_if.slave  bus,
    output logic [N:0]  r0,
    output logic [N:0]  r1,
    output logic [N:0]  r2,
    output logic [N:0]  r3,
    output logic [N:0]  r4,
    output logic [N:0]  r5,
    output logic [N:0]  r6,
    output logic [N:0]  r7,
    output logic [N:0]  r8,
    output logic [N:0]  r9,
    output logic [N:0]  r10,
    output logic [N:0]  r11,
    output logic [N:0]  r12,
    output logic [N:0]  r13,
    output logic [N:0]  r14,
    output logic [N:0]  r15
);

    // The address spans exactly REG_COUNT entries, so all-ones is the last one.
    localparam logic [J:0] PTR_LAST = '1;
    localparam logic [J:0] PTR_ONE  = {{J{1'b0}}, 1'b1};

    logic [0:0] state_q,    state_d;
    logic [J:0] ptr_q,      ptr_d;
    logic [N:0] mem_q [REG_COUNT];
    logic [N:0] mem_d [REG_COUNT];
    logic       wr_ack_q,   wr_ack_d;
    logic       busy_q,     busy_d;
    logic       clr_done_q, clr_done_d;

    logic       wr_fire;

    // Ready is the only combinational output: it must drop in the same cycle
    // rst is raised and stay low for the whole sweep.
    assign bus.wr_ready = (state_q == IDLE) && !rst;
    assign wr_fire      = bus.wr_valid && bus.wr_ready;

    always_comb begin
        // NOTE: every *_d takes its hold value first, so no branch can leave a
        // signal unassigned and infer a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        mem_d      = mem_q;
        wr_ack_d   = wr_fire;
        clr_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A write and a clear request at the same edge are both
                // honoured; the sweep later zeroes the freshly written entry.
                if (wr_fire) begin
                    mem_d[bus.wr_addr] = bus.wr_data;
                end
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end

            CLEAR: begin
                // clr_req is not looked at here: a sweep cannot be extended
                // or restarted once it is running.
                mem_d[ptr_q] = '0;
                if (ptr_q == PTR_LAST) begin
                    state_d    = IDLE;
                    ptr_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + PTR_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase

        // Registered copy of the next state so busy is glitch-free.
        busy_d = (state_d == CLEAR);
    end

    // Pointer, FSM and storage array share one sequential block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            wr_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            // NOTE: the storage array is reset too, because downstream logic
            // relies on every operand reading 0 after reset, not X.
            for (int i = 0; i < REG_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed before this edge, independent of statement order.
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wr_ack_q   <= wr_ack_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.wr_ack   = wr_ack_q;
    assign bus.busy     = busy_q;
    assign bus.clr_done = clr_done_q;

    // Port order matches the mux16 inputs r0..r15.
    assign r0  = mem_q[0];
    assign r1  = mem_q[1];
    assign r2  = mem_q[2];
    assign r3  = mem_q[3];
    assign r4  = mem_q[4];
    assign r5  = mem_q[5];
    assign r6  = mem_q[6];
    assign r7  = mem_q[7];
    assign r8  = mem_q[8];
    assign r9  = mem_q[9];
    assign r10 = mem_q[10];
    assign r11 = mem_q[11];
    assign r12 = mem_q[12];
    assign r13 = mem_q[13];
    assign r14 = mem_q[14];
    assign r15 = mem_q[15];

endmodule

// File: tb/tb_regbank16.sv
// ----------------------------------------------------------------------------
// tb_regbank16
//   Self-checking bench for regbank16: a table of single-cycle write vectors
//   followed by hand-written sequences for back-to-back writes, the clear
//   sweep, write+clear collision and reset in the middle of a sweep.
// ----------------------------------------------------------------------------
module tb_regbank16;

    localparam int TB_N = 19;
    localparam int TB_J = 3;

    logic clk;
    logic rst;

    regbank16_if #(.N(TB_N), .J(TB_J)) bus ();

    wire [TB_N:0] r [16];

    regbank16 #(.N(TB_N), .J(TB_J)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .r0  (r[0]),
        .r1  (r[1]),
        .r2  (r[2]),
        .r3  (r[3]),
        .r4  (r[4]),
        .r5  (r[5]),
        .r6  (r[6]),
        .r7  (r[7]),
        .r8  (r[8]),
        .r9  (r[9]),
        .r10 (r[10]),
        .r11 (r[11]),
        .r12 (r[12]),
        .r13 (r[13]),
        .r14 (r[14]),
        .r15 (r[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [TB_N:0] exp_mem [16];

    typedef struct {
        logic          wv;
        logic [TB_J:0] addr;
        logic [TB_N:0] data;
        logic          exp_ack;
        logic [TB_J:0] chk_addr;
        logic [TB_N:0] chk_val;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s r%0d", tag, i), 32'(r[i]), 32'(exp_mem[i]));
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [TB_J:0] opc;
        logic [TB_N:0] mux_out;
        int            busy_cnt;
        int            waited;
        int            done_cnt;

        vecs[0] = '{1'b1, 4'h5, 20'hABCDE, 1'b1, 4'h5, 20'hABCDE};
        vecs[1] = '{1'b0, 4'h5, 20'h00000, 1'b0, 4'h5, 20'hABCDE};
        vecs[2] = '{1'b1, 4'h0, 20'h00001, 1'b1, 4'h0, 20'h00001};
        vecs[3] = '{1'b1, 4'hF, 20'h80000, 1'b1, 4'hF, 20'h80000};
        vecs[4] = '{1'b1, 4'h5, 20'h12345, 1'b1, 4'h5, 20'h12345};
        vecs[5] = '{1'b1, 4'hA, 20'hFFFFF, 1'b1, 4'hA, 20'hFFFFF};
        vecs[6] = '{1'b0, 4'hA, 20'h00000, 1'b0, 4'hA, 20'hFFFFF};
        vecs[7] = '{1'b1, 4'h0, 20'h00000, 1'b1, 4'h0, 20'h00000};

        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 1'b0;
        clear_model();

        // ---------------- reset ----------------
        tick();
        check("reset wr_ready cyc1", 32'(bus.wr_ready), 32'd0);
        tick();
        check("reset wr_ready cyc2", 32'(bus.wr_ready), 32'd0);
        check("reset busy",          32'(bus.busy),     32'd0);
        check("reset wr_ack",        32'(bus.wr_ack),   32'd0);
        check("reset clr_done",      32'(bus.clr_done), 32'd0);
        check_bank("reset");
        rst = 1'b0;
        #1;
        check("post-reset wr_ready", 32'(bus.wr_ready), 32'd1);

        // ---------------- table-driven single writes ----------------
        for (int v = 0; v < 8; v++) begin
            bus.wr_valid = vecs[v].wv;
            bus.wr_addr  = vecs[v].addr;
            bus.wr_data  = vecs[v].data;
            tick();
            if (vecs[v].wv) exp_mem[vecs[v].addr] = vecs[v].data;
            check($sformatf("vec%0d wr_ack", v), 32'(bus.wr_ack), 32'(vecs[v].exp_ack));
            check($sformatf("vec%0d r%0d", v, vecs[v].chk_addr),
                  32'(r[vecs[v].chk_addr]), 32'(vecs[v].chk_val));
            check($sformatf("vec%0d busy", v), 32'(bus.busy), 32'd0);
            check_bank($sformatf("vec%0d", v));
        end
        bus.wr_valid = 1'b0;
        tick();
        check("idle wr_ack low", 32'(bus.wr_ack), 32'd0);

        // ---------------- back-to-back writes ----------------
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 4'(i);
            bus.wr_data  = 20'h10000 + 20'(i);
            tick();
            exp_mem[i] = 20'h10000 + 20'(i);
            check($sformatf("b2b r%0d", i), 32'(r[i]), 32'h10000 + 32'(i));
            check($sformatf("b2b wr_ack %0d", i), 32'(bus.wr_ack), 32'd1);
        end
        bus.wr_valid = 1'b0;
        opc     = 4'hF;
        mux_out = r[opc];
        check("mux16 readback opc F", 32'(mux_out), 32'h1000F);
        check_bank("b2b");
        tick();
        check("b2b wr_ack drops", 32'(bus.wr_ack), 32'd0);

        // ---------------- clear sweep ----------------
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 4'(i);
            bus.wr_data  = 20'hFFFFF;
            tick();
            exp_mem[i] = 20'hFFFFF;
        end
        check_bank("fill");
        bus.wr_valid = 1'b0;
        bus.clr_req  = 1'b1;
        tick();
        // Hold a write request through the sweep; it must wait for IDLE.
        bus.clr_req  = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'h7;
        bus.wr_data  = 20'h2A5A5;
        busy_cnt     = 0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("sweep%0d busy", i),     32'(bus.busy),     32'd1);
            check($sformatf("sweep%0d wr_ready", i), 32'(bus.wr_ready), 32'd0);
            check($sformatf("sweep%0d clr_done", i), 32'(bus.clr_done), 32'd0);
            check($sformatf("sweep%0d wr_ack", i),   32'(bus.wr_ack),   32'd0);
            check($sformatf("sweep%0d r%0d kept", i, i), 32'(r[i]), 32'hFFFFF);
            if (i > 0) check($sformatf("sweep%0d r%0d cleared", i, i - 1), 32'(r[i - 1]), 32'd0);
            if (bus.busy) busy_cnt++;
            // A stray clr_req during the sweep must be ignored.
            if (i == 5) bus.clr_req = 1'b1;
            if (i == 6) bus.clr_req = 1'b0;
            tick();
        end
        check("sweep busy cycles", 32'(busy_cnt),     32'd16);
        check("sweep end busy",    32'(bus.busy),     32'd0);
        check("sweep end clr_done",32'(bus.clr_done), 32'd1);
        check("sweep end wr_ready",32'(bus.wr_ready), 32'd1);
        check("sweep end wr_ack",  32'(bus.wr_ack),   32'd0);
        clear_model();
        check_bank("sweep end");
        tick();
        exp_mem[7] = 20'h2A5A5;
        check("held write wr_ack",   32'(bus.wr_ack),   32'd1);
        check("held write r7",       32'(r[7]),         32'h2A5A5);
        check("clr_done single",     32'(bus.clr_done), 32'd0);
        check("no restart busy",     32'(bus.busy),     32'd0);
        bus.wr_valid = 1'b0;

        // ---------------- simultaneous write + clear ----------------
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'h3;
        bus.wr_data  = 20'h12345;
        bus.clr_req  = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        bus.clr_req  = 1'b0;
        check("sim wr_ack", 32'(bus.wr_ack), 32'd1);
        check("sim busy",   32'(bus.busy),   32'd1);
        check("sim r3 c0",  32'(r[3]),       32'h12345);
        for (int j = 1; j <= 3; j++) begin
            tick();
            check($sformatf("sim r3 c%0d", j), 32'(r[3]), 32'h12345);
        end
        tick();
        check("sim r3 after 4th edge", 32'(r[3]), 32'd0);
        waited = 0;
        while (!bus.clr_done && waited < 20) begin
            tick();
            waited++;
        end
        check("sim clr_done latency", 32'(waited), 32'd12);
        clear_model();
        check_bank("sim end");

        // ---------------- reset mid-sweep ----------------
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'hC;
        bus.wr_data  = 20'hABCDE;
        tick();
        bus.wr_addr  = 4'h2;
        bus.wr_data  = 20'h55555;
        tick();
        bus.wr_valid = 1'b0;
        bus.clr_req  = 1'b1;
        tick();
        bus.clr_req  = 1'b0;
        repeat (7) tick();
        check("mid r12 not reached", 32'(r[12]), 32'hABCDE);
        check("mid r2 cleared",      32'(r[2]),  32'd0);
        check("mid busy",            32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid rst wr_ready", 32'(bus.wr_ready), 32'd0);
        tick();
        check("mid rst busy",     32'(bus.busy),     32'd0);
        check("mid rst clr_done", 32'(bus.clr_done), 32'd0);
        check("mid rst wr_ack",   32'(bus.wr_ack),   32'd0);
        check_bank("mid rst");
        rst = 1'b0;
        #1;
        check("mid rst wr_ready after", 32'(bus.wr_ready), 32'd1);
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.clr_done) done_cnt++;
            if (bus.busy) busy_cnt++;
        end
        check("mid rst no clr_done", 32'(done_cnt), 32'd0);
        check("mid rst stays idle",  32'(busy_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
